// File: rtl/spi_mode0_slave.sv
// spi_mode0_slave
//   SPI mode 0 (CPOL=0, CPHA=0) slave endpoint. SCLK, CS and DI are
//   oversampled on clk, received bits are shifted in MSB-first and each
//   completed word is offered on a valid/ready interface. The response word
//   is shifted out on DO within the same frame.
//
// state  | meaning
// IDLE   | no frame in progress, DO held low, SCLK edges ignored
// ACTIVE | frame in progress, shifting DI in and tx word out on DO
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   SCLK/CS/DI SPI pins from master (asynchronous to clk), CS active low
//   DO         serial data to master
//   tx_data    response word, sampled at frame start and each word boundary
//   rx_data    last received word
//   rx_valid   rx_data holds an unconsumed word
//   rx_ready   consumer accepts rx_data
//   frame_err  one-cycle pulse: CS released with a partial word
//   overrun    one-cycle pulse: completed word dropped (rx_valid pending)
//   busy       high while a frame is active
module spi_mode0_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              DI,
  output logic              DO,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] di_sync_q, di_sync_d;
  logic [SYNC_STAGES-1:0] sync_vld_q, sync_vld_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   armed_q, armed_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   word_seen_q, word_seen_d;
  logic [DATA_W-1:0]      rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
  logic                   do_q, do_d;
  logic                   word_done_q, word_done_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic sclk_s, cs_s, di_s;
  logic rise, fall, cs_fall, cs_rise;

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign di_s    = di_sync_q[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_prev_q;
  assign fall    = ~sclk_s & sclk_prev_q;
  assign cs_fall = ~cs_s & cs_prev_q;
  assign cs_rise = cs_s & ~cs_prev_q;

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
    di_sync_d   = {di_sync_q[SYNC_STAGES-2:0], DI};
    // Marks when the CS chain holds real pin samples rather than its reset
    // preset, so a CS held low through reset cannot arm a frame.
    sync_vld_d  = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    armed_d     = armed_q | (cs_s & sync_vld_q[SYNC_STAGES-1]);
    bit_cnt_d   = bit_cnt_q;
    word_seen_d = word_seen_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    do_d        = do_q;
    word_done_d = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        do_d = 1'b0;
        if (cs_fall && armed_q) begin
          state_d     = ST_ACTIVE;
          armed_d     = 1'b0;
          bit_cnt_d   = '0;
          word_seen_d = 1'b0;
          tx_shift_d  = tx_data;
          do_d        = tx_data[DATA_W-1];
        end
      end
      ST_ACTIVE: begin
        // cs_rise wins over a same-cycle SCLK rise.
        if (cs_rise) begin
          state_d     = ST_IDLE;
          do_d        = 1'b0;
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
        end else if (rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], di_s};
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d   = '0;
            word_done_d = 1'b1;
            word_seen_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (fall) begin
          if (bit_cnt_q != '0) begin
            tx_shift_d = tx_shift_q << 1;
            do_d       = tx_shift_q[DATA_W-2];
          end else if (word_seen_q) begin
            // First fall of the next word in a multi-word frame.
            tx_shift_d = tx_data;
            do_d       = tx_data[DATA_W-1];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Delivery runs off the registered completion flag, independent of the
    // FSM, so a word finished just before CS release still goes out.
    if (word_done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      di_sync_q   <= '0;
      sync_vld_q  <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      word_seen_q <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      do_q        <= 1'b0;
      word_done_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      di_sync_q   <= di_sync_d;
      sync_vld_q  <= sync_vld_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      word_seen_q <= word_seen_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      do_q        <= do_d;
      word_done_q <= word_done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign DO        = do_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_mode0_slave.sv
module tb_spi_mode0_slave;
  localparam int W = 8;
  localparam int S = 2;
  localparam int H = 2;  // clk cycles per SCLK phase (SCLK = clk/4)

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sclk = 1'b0;
  logic         cs = 1'b1;
  logic         di = 1'b0;
  logic         rx_ready = 1'b1;
  logic [W-1:0] tx_data = '0;
  logic         do_o;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  spi_mode0_slave #(.DATA_W(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .SCLK(sclk), .CS(cs), .DI(di), .DO(do_o),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Observation of the delivery interface, sampled on the falling edge.
  logic [W-1:0] got_q[$];
  int           ovr_cnt = 0;
  int           ferr_cnt = 0;
  int           unstable_cnt = 0;
  int           vrise_cyc = 0;
  logic         prev_valid = 1'b0;
  logic [W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (overrun) ovr_cnt++;
    if (frame_err) ferr_cnt++;
    if (rx_valid && !prev_valid) vrise_cyc = cyc;
    if (prev_valid && rx_valid && rx_data !== prev_data) unstable_cnt++;
    prev_valid = rx_valid;
    prev_data  = rx_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [W-1:0] fr_rx[4];
  logic [W-1:0] fr_tx[4];
  logic [W-1:0] fr_do[4];
  int           last_rise_cyc = 0;
  logic         busy_at_start = 1'b0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit: DI set in the low phase, SCLK high for H cycles; DO is read at
  // the end of the high phase (the master's view of the bit for this rise).
  task automatic send_bit(input logic b, output logic dob);
    di = b;
    tick(H);
    sclk = 1'b1;
    last_rise_cyc = cyc;
    tick(H);
    dob = do_o;
    sclk = 1'b0;
  endtask

  task automatic run_frame(input int nbits);
    logic b;
    tx_data = fr_tx[0];
    cs = 1'b0;
    tick(4);
    busy_at_start = busy;
    for (int i = 0; i < nbits; i++) begin
      int w;
      int k;
      w = i / W;
      k = W - 1 - (i % W);
      if ((i % W) == 4 && w + 1 < 4) tx_data = fr_tx[w + 1];
      send_bit(fr_rx[w][k], b);
      fr_do[w][k] = b;
    end
    tick(H);
    cs = 1'b1;
    tick(8);
  endtask

  initial begin
    int g0, o0, f0, n;
    logic b;

    // Reset state
    tick(3);
    check("rst_do", 32'(do_o), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(8);

    // Single word 0xB1 in, 0x5A out
    g0 = got_q.size(); o0 = ovr_cnt; f0 = ferr_cnt;
    fr_rx[0] = 8'hB1; fr_tx[0] = 8'h5A;
    run_frame(8);
    check("single_busy", 32'(busy_at_start), 32'd1);
    check("single_cnt", 32'(got_q.size() - g0), 32'd1);
    if (got_q.size() > g0) check("single_data", 32'(got_q[g0]), 32'hB1);
    check("single_do", 32'(fr_do[0]), 32'h5A);
    check("single_latency", 32'(vrise_cyc - last_rise_cyc), 32'(S + 2));
    check("single_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("single_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("single_do_idle", 32'(do_o), 32'd0);
    check("single_busy_end", 32'(busy), 32'd0);
    check("single_valid_end", 32'(rx_valid), 32'd0);

    // Two words with consumer stalled
    rx_ready = 1'b0;
    g0 = got_q.size(); o0 = ovr_cnt;
    fr_rx[0] = 8'h12; fr_rx[1] = 8'h34; fr_tx[0] = 8'hC3; fr_tx[1] = 8'h96;
    run_frame(16);
    check("bp_ovr", 32'(ovr_cnt - o0), 32'd1);
    check("bp_data", 32'(rx_data), 32'h12);
    check("bp_valid", 32'(rx_valid), 32'd1);
    check("bp_do0", 32'(fr_do[0]), 32'hC3);
    check("bp_do1", 32'(fr_do[1]), 32'h96);
    rx_ready = 1'b1;
    tick(2);
    check("bp_cnt", 32'(got_q.size() - g0), 32'd1);
    if (got_q.size() > g0) check("bp_consumed", 32'(got_q[g0]), 32'h12);
    check("bp_valid_clr", 32'(rx_valid), 32'd0);

    // Back-to-back with consumer ready
    g0 = got_q.size(); o0 = ovr_cnt;
    fr_rx[0] = 8'hA5; fr_rx[1] = 8'h3C; fr_tx[0] = 8'h0F; fr_tx[1] = 8'hE1;
    run_frame(16);
    check("b2b_cnt", 32'(got_q.size() - g0), 32'd2);
    if (got_q.size() > g0 + 1) begin
      check("b2b_w0", 32'(got_q[g0]), 32'hA5);
      check("b2b_w1", 32'(got_q[g0 + 1]), 32'h3C);
    end
    check("b2b_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("b2b_do1", 32'(fr_do[1]), 32'hE1);

    // Abort after 5 bits, then a clean frame
    g0 = got_q.size(); f0 = ferr_cnt;
    fr_rx[0] = 8'hD7; fr_tx[0] = 8'h00;
    run_frame(5);
    check("abort_ferr", 32'(ferr_cnt - f0), 32'd1);
    check("abort_cnt", 32'(got_q.size() - g0), 32'd0);
    fr_rx[0] = 8'hFF;
    run_frame(8);
    check("after_abort_cnt", 32'(got_q.size() - g0), 32'd1);
    if (got_q.size() > g0) check("after_abort_data", 32'(got_q[g0]), 32'hFF);
    check("after_abort_ferr", 32'(ferr_cnt - f0), 32'd1);

    // Reset three bits into a frame; the rest of that frame is ignored
    g0 = got_q.size(); f0 = ferr_cnt;
    fr_rx[0] = 8'hE7; tx_data = 8'hFF;
    cs = 1'b0;
    tick(4);
    for (int i = 0; i < 3; i++) send_bit(fr_rx[0][W - 1 - i], b);
    rst = 1'b1;
    tick(1);
    check("mrst_do", 32'(do_o), 32'd0);
    check("mrst_rx_data", 32'(rx_data), 32'd0);
    check("mrst_rx_valid", 32'(rx_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 3; i < W; i++) begin
      send_bit(fr_rx[0][W - 1 - i], b);
      check("mrst_do_quiet", 32'(b), 32'd0);
    end
    tick(H);
    cs = 1'b1;
    tick(8);
    check("mrst_cnt", 32'(got_q.size() - g0), 32'd0);
    check("mrst_ferr", 32'(ferr_cnt - f0), 32'd0);
    fr_rx[0] = 8'h81; fr_tx[0] = 8'h24;
    run_frame(8);
    check("mrst_next_data", 32'(rx_data), 32'h81);
    check("mrst_next_cnt", 32'(got_q.size() - g0), 32'd1);
    check("mrst_next_do", 32'(fr_do[0]), 32'h24);

    // Random multi-word frames against the word-level model
    for (int f = 0; f < 6; f++) begin
      n = int'($urandom_range(1, 3));
      for (int j = 0; j < 4; j++) begin
        fr_rx[j] = 8'($urandom);
        fr_tx[j] = 8'($urandom);
      end
      g0 = got_q.size(); o0 = ovr_cnt; f0 = ferr_cnt;
      run_frame(n * W);
      check("rnd_cnt", 32'(got_q.size() - g0), 32'(n));
      for (int j = 0; j < n; j++) begin
        if (got_q.size() > g0 + j) check("rnd_rx", 32'(got_q[g0 + j]), 32'(fr_rx[j]));
        check("rnd_do", 32'(fr_do[j]), 32'(fr_tx[j]));
      end
      check("rnd_ovr", 32'(ovr_cnt - o0), 32'd0);
      check("rnd_ferr", 32'(ferr_cnt - f0), 32'd0);
    end

    check("rx_data_stable", 32'(unstable_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
